caparray_sar_ctrl: RTL
======================

// Module: caparray_sar_ctrl
// PURPOSE
//  Synchronous SAR sequencer for the parametrised caparray capacitive DAC.
//  Drives the sampling switch, the main and diff bottom-plate words, and the comparator strobe.
//  Binary-searches the main array (normal mode) or the diff array (cal mode) and returns the final code.
//  Sits between the digital top and the analog caparray/comparator pair.
// PARAMETERS
//  N_BITS      16  width of the main and diff bottom-plate words and of the result
//  SAMPLE_CYC  4   cycles samp_en is held high per conversion (legal range >=1)
//  SETTLE_CYC  1   DAC settling cycles after each bit trial before the strobe (legal range >=1)
// PORTS
//  clk               in   1       clock
//  rst               in   1       synchronous reset, active-high
//  start             in   1       conversion request; sampled only in IDLE
//  cal_en            in   1       sampled with start; 1 = SAR runs on the diff array
//  diff_trim         in   N_BITS  offset trim word; sampled with start; normal mode only
//  comp_out          in   1       comparator decision; 1 = keep trial bit; sampled in DECIDE
//  samp_en           out  1       sampling-switch enable (cap_topplate_in path)
//  comp_strobe       out  1       comparator clock pulse
//  cap_botplate_main out  N_BITS  main-array bottom-plate word
//  cap_botplate_diff out  N_BITS  diff-array bottom-plate word
//  busy              out  1       high in every state except IDLE
//  result            out  N_BITS  final code; valid while result_valid=1
//  result_valid      out  1       one-cycle pulse in DONE
//  result_is_cal     out  1       mode of the current result (cal_en captured at start)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0 at the edge where rst=1, including the main/diff words, result and flags.
//  rst has priority over all other inputs in every state, including mid-conversion. No partial result is emitted.
//  FSM: IDLE -> SAMPLE -> {SETTLE -> STROBE -> DECIDE} x N_BITS -> DONE -> IDLE.
//  IDLE: when start=1, capture cal_en and diff_trim, then go to SAMPLE. start is ignored in all other states (no queueing).
//  SAMPLE, lasting SAMPLE_CYC cycles:
//    samp_en=1 and main word=0.
//    Diff word = captured diff_trim in normal mode; 0 in cal mode.
//  Bit index i runs from N_BITS-1 down to 0. Target word = main in normal mode, diff in cal mode; the other word holds its SAMPLE value.
//  SETTLE, lasting SETTLE_CYC cycles: target[i]=1 on the entry edge.
//  STROBE, 1 cycle: comp_strobe=1. comp_strobe is 0 in every other state.
//  DECIDE, 1 cycle: comp_out is sampled at the cycle end.
//    comp_out=0 -> clear target[i].
//    comp_out=1 -> keep target[i].
//    i=0 -> DONE; otherwise i-1 -> SETTLE.
//  DONE, 1 cycle: result=final target word, result_valid=1, result_is_cal=captured cal_en. Go to IDLE.
//  Holding after DONE: result, result_is_cal and both bottom-plate words hold until the next start or rst.
//  Latency: start high in IDLE at edge t0 -> result_valid high in cycle t0+1+SAMPLE_CYC+N_BITS*(SETTLE_CYC+2).
//    With default parameters this is 53 cycles.
//  start in the DONE cycle is ignored. The earliest accepted restart is the cycle after DONE (IDLE).
//  A new start overwrites result and the captured mode.
//  Internal counters: sample counter clog2(SAMPLE_CYC+1) bits, settle counter clog2(SETTLE_CYC+1) bits, bit index clog2(N_BITS) bits.
//  No arithmetic overflow is possible on any counter.
// TESTING
//  Bench comparator model: comp_out = (target_code_at_strobe <= vin_code), registered into DECIDE.
//  T1 normal, vin=0xA5A5, diff_trim=0x0003
//     -> result=0xA5A5 at cycle 53; diff word=0x0003 throughout; result_is_cal=0.
//  T2 comp_out tied 1 -> result=0xFFFF; comp_out tied 0 -> result=0x0000.
//     Check comp_strobe pulse count = 16 per conversion in both cases.
//  T3 cal_en=1, vin=0x0123 -> main word stays 0x0000, result=0x0123, result_is_cal=1.
//  T4 start re-asserted at cycles 10 and 53 (DONE) -> both ignored;
//     next start at cycle 54 accepted; busy low exactly 1 cycle between the conversions.
//  T5 rst asserted in the 8th DECIDE -> next cycle all outputs 0, state IDLE, no result_valid;
//     a fresh start completes normally.
//  T6 SAMPLE_CYC=1, SETTLE_CYC=3, N_BITS=8 -> latency 1+1+8*5=42 cycles;
//     samp_en high exactly 1 cycle.

Source files
------------

// File: rtl/caparray_sar_ctrl.sv
// SAR sequencer for the caparray capacitive DAC: samples, binary-searches the main
// array (normal mode) or the diff array (cal mode) bit by bit, and reports the final code.
module caparray_sar_ctrl #(
    parameter int N_BITS     = 16,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cal_en,
    input  logic [N_BITS-1:0] diff_trim,
    input  logic              comp_out,
    output logic              samp_en,
    output logic              comp_strobe,
    output logic [N_BITS-1:0] cap_botplate_main,
    output logic [N_BITS-1:0] cap_botplate_diff,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              result_valid,
    output logic              result_is_cal
);

    localparam int SAMP_W = $clog2(SAMPLE_CYC + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_SETTLE,
        S_STROBE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [SAMP_W-1:0]   samp_cnt_reg, samp_cnt_next;
    logic [SET_W-1:0]    settle_cnt_reg, settle_cnt_next;
    logic [BIT_W-1:0]    bit_idx_reg, bit_idx_next;
    logic                cal_reg, cal_next;
    logic [N_BITS-1:0]   main_reg, main_next;
    logic [N_BITS-1:0]   diff_reg, diff_next;
    logic [N_BITS-1:0]   result_reg, result_next;
    logic                result_is_cal_reg, result_is_cal_next;

    logic [N_BITS-1:0]   bit_mask;
    logic [N_BITS-1:0]   target_word;
    logic [N_BITS-1:0]   decided_word;

    // One-hot mask of the bit currently under trial.
    generate
        for (genvar gi = 0; gi < N_BITS; gi++) begin : g_bit_mask
            assign bit_mask[gi] = (bit_idx_reg == BIT_W'(gi));
        end
    endgenerate

    assign target_word  = cal_reg ? diff_reg : main_reg;
    assign decided_word = comp_out ? target_word : (target_word & ~bit_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            samp_cnt_reg      <= '0;
            settle_cnt_reg    <= '0;
            bit_idx_reg       <= '0;
            cal_reg           <= 1'b0;
            main_reg          <= '0;
            diff_reg          <= '0;
            result_reg        <= '0;
            result_is_cal_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            samp_cnt_reg      <= samp_cnt_next;
            settle_cnt_reg    <= settle_cnt_next;
            bit_idx_reg       <= bit_idx_next;
            cal_reg           <= cal_next;
            main_reg          <= main_next;
            diff_reg          <= diff_next;
            result_reg        <= result_next;
            result_is_cal_reg <= result_is_cal_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        samp_cnt_next      = samp_cnt_reg;
        settle_cnt_next    = settle_cnt_reg;
        bit_idx_next       = bit_idx_reg;
        cal_next           = cal_reg;
        main_next          = main_reg;
        diff_next          = diff_reg;
        result_next        = result_reg;
        result_is_cal_next = result_is_cal_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next         = S_SAMPLE;
                    cal_next           = cal_en;
                    main_next          = '0;
                    diff_next          = cal_en ? '0 : diff_trim;
                    samp_cnt_next      = '0;
                    bit_idx_next       = BIT_W'(N_BITS - 1);
                    result_next        = '0;
                    result_is_cal_next = cal_en;
                end
            end
            S_SAMPLE: begin
                if (samp_cnt_reg == SAMP_W'(SAMPLE_CYC - 1)) begin
                    state_next      = S_SETTLE;
                    settle_cnt_next = '0;
                    if (cal_reg) diff_next = target_word | bit_mask;
                    else         main_next = target_word | bit_mask;
                end else begin
                    samp_cnt_next = samp_cnt_reg + 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_reg == SET_W'(SETTLE_CYC - 1)) state_next = S_STROBE;
                else settle_cnt_next = settle_cnt_reg + 1'b1;
            end
            S_STROBE: begin
                state_next = S_DECIDE;
            end
            S_DECIDE: begin
                // Resolve the current bit; if more remain, raise the next trial bit on the same edge.
                if (bit_idx_reg == '0) begin
                    state_next  = S_DONE;
                    result_next = decided_word;
                    if (cal_reg) diff_next = decided_word;
                    else         main_next = decided_word;
                end else begin
                    state_next      = S_SETTLE;
                    settle_cnt_next = '0;
                    bit_idx_next    = bit_idx_reg - 1'b1;
                    if (cal_reg) diff_next = decided_word | (bit_mask >> 1);
                    else         main_next = decided_word | (bit_mask >> 1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign samp_en           = (state_reg == S_SAMPLE);
    assign comp_strobe       = (state_reg == S_STROBE);
    assign result_valid      = (state_reg == S_DONE);
    assign busy              = (state_reg != S_IDLE);
    assign cap_botplate_main = main_reg;
    assign cap_botplate_diff = diff_reg;
    assign result            = result_reg;
    assign result_is_cal     = result_is_cal_reg;

endmodule
